// File: rtl/serv_rf_dbg_arbiter.sv
// Shares the RF RAM between the core RAM-side port and a 32-bit debug register port.
// Optional SERV_DBG_RF_CSR_EN makes CSR slots (reg 32..32+CSR_REGS-1) debug-accessible.
module serv_rf_dbg_arbiter #(
   parameter int RF_WIDTH = 8,
   parameter int CSR_REGS = 4,
   parameter int RF_L2D   = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH)
) (
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic [RF_L2D-1:0]   i_core_waddr,
   input  logic [RF_WIDTH-1:0] i_core_wdata,
   input  logic                i_core_wen,
   input  logic [RF_L2D-1:0]   i_core_raddr,
   input  logic                i_core_ren,
   output logic [RF_WIDTH-1:0] o_core_rdata,
   output logic [RF_L2D-1:0]   o_ram_waddr,
   output logic [RF_WIDTH-1:0] o_ram_wdata,
   output logic                o_ram_wen,
   output logic [RF_L2D-1:0]   o_ram_raddr,
   output logic                o_ram_ren,
   input  logic [RF_WIDTH-1:0] i_ram_rdata,
   input  logic                i_dbg_halted,
   input  logic                i_dbg_req,
   input  logic                i_dbg_we,
   input  logic [5:0]          i_dbg_reg,
   input  logic [31:0]         i_dbg_wdata,
   output logic                o_dbg_ack,
   output logic [31:0]         o_dbg_rdata,
   output logic                o_dbg_err,
   output logic                o_conflict
);

   localparam int BEATS = 32 / RF_WIDTH;
   localparam int BL2   = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef SERV_DBG_RF_CSR_EN
   localparam int NREGS = 32 + CSR_REGS;
`else
   localparam int NREGS = 32;
`endif
   localparam logic [6:0] NREGS_L = 7'(NREGS);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ACK} state_t;

   state_t              state_q;
   logic [BL2-1:0]      cnt_q, cnt_d;
   logic [5:0]          reg_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic                ack_q, err_q;
   logic                last_beat, reg_ok, accept;
   logic [BL2-1:0]      cap_idx;
   logic [RF_L2D-1:0]   dbg_addr;
   logic [RF_WIDTH-1:0] wbeat [BEATS];

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wbeat[gi] = wdata_q[gi*RF_WIDTH +: RF_WIDTH];
   end

   assign cnt_d     = cnt_q + BL2'(1);
   assign last_beat = (cnt_q == BL2'(BEATS - 1));
   assign reg_ok    = ({1'b0, i_dbg_reg} < NREGS_L);
   assign accept    = i_dbg_req & ~i_core_ren & ~i_core_wen;
   assign dbg_addr  = RF_L2D'(32'(reg_q) * 32'(BEATS) + 32'(cnt_q));
   // In RD the RAM answers the previous cycle's beat; RDW collects the last one.
   assign cap_idx   = (state_q == S_RDW) ? BL2'(BEATS - 1) : cnt_q - BL2'(1);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  reg_q   <= i_dbg_reg;
                  wdata_q <= i_dbg_wdata;
                  cnt_q   <= '0;
                  if (!i_dbg_halted || !reg_ok) begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (i_dbg_we && i_dbg_reg == 6'd0) begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= i_dbg_we ? S_WR : S_RD;
                  end
               end
            end
            S_WR: begin
               cnt_q <= cnt_d;
               if (last_beat) begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
               end
            end
            S_RD: begin
               if (cnt_q != '0)
                  rdata_q[cap_idx*RF_WIDTH +: RF_WIDTH] <= i_ram_rdata;
               cnt_q <= cnt_d;
               if (last_beat)
                  state_q <= S_RDW;
            end
            S_RDW: begin
               rdata_q[cap_idx*RF_WIDTH +: RF_WIDTH] <= i_ram_rdata;
               state_q <= S_ACK;
               ack_q   <= 1'b1;
            end
            S_ACK:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_ram_waddr = i_core_waddr;
      o_ram_wdata = i_core_wdata;
      o_ram_wen   = i_core_wen;
      o_ram_raddr = i_core_raddr;
      o_ram_ren   = i_core_ren;
      if (state_q != S_IDLE) begin
         o_ram_waddr = dbg_addr;
         o_ram_wdata = wbeat[cnt_q];
         o_ram_wen   = (state_q == S_WR);
         o_ram_raddr = dbg_addr;
         o_ram_ren   = (state_q == S_RD);
      end
   end

   assign o_core_rdata = i_ram_rdata;
   assign o_conflict   = (state_q != S_IDLE) & (i_core_ren | i_core_wen);
   assign o_dbg_ack    = ack_q;
   assign o_dbg_err    = err_q;
   assign o_dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_serv_rf_dbg_arbiter.sv
// Self-checking bench for serv_rf_dbg_arbiter: RAM model plus a register-level reference model.
// Honours SERV_DBG_RF_CSR_EN when deciding which register indices are legal.
module tb_serv_rf_dbg_arbiter;
   localparam int W     = 8;
   localparam int BEATS = 4;
   localparam int L2D   = 8;
`ifdef SERV_DBG_RF_CSR_EN
   localparam int NREGS = 36;
`else
   localparam int NREGS = 32;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [L2D-1:0] core_waddr = '0, core_raddr = '0;
   logic [W-1:0]   core_wdata = '0, core_rdata;
   logic           core_wen = 1'b0, core_ren = 1'b0;
   logic [L2D-1:0] ram_waddr, ram_raddr;
   logic [W-1:0]   ram_wdata, ram_rdata = '0;
   logic           ram_wen, ram_ren;
   logic           dbg_halted = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
   logic [5:0]     dbg_reg = '0;
   logic [31:0]    dbg_wdata = '0, dbg_rdata;
   logic           dbg_ack, dbg_err, conflict;

   int             n_checks = 0;
   int             n_fail   = 0;
   logic [7:0]     init_img [0:255];
   logic [7:0]     ram      [0:255];
   logic           fill = 1'b0;
   logic [31:0]    model    [0:63];
   logic [31:0]    exp_rdata = '0;

   serv_rf_dbg_arbiter dut (
      .clk(clk), .i_rst_n(rst_n),
      .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
      .i_core_raddr(core_raddr), .i_core_ren(core_ren), .o_core_rdata(core_rdata),
      .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata), .o_ram_wen(ram_wen),
      .o_ram_raddr(ram_raddr), .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata),
      .i_dbg_halted(dbg_halted), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
      .i_dbg_reg(dbg_reg), .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack),
      .o_dbg_rdata(dbg_rdata), .o_dbg_err(dbg_err), .o_conflict(conflict)
   );

   always #5 clk = ~clk;

   // RF RAM with one-cycle registered read
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_img[i];
      end else begin
         if (ram_wen) ram[ram_waddr] <= ram_wdata;
         if (ram_ren) ram_rdata <= ram[ram_raddr];
      end
   end

   // One debug transaction, cycle 0 = request cycle; optional core access injected at cycle cf.
   task automatic do_access(input logic we, input logic [5:0] r, input logic [31:0] wd,
                            input logic halted, input int cf, input logic cf_wen);
      logic ok, inj, e_wen, e_ren;
      int exp_ack;
      logic [7:0] e_addr;
      logic [31:0] e_rd;
      ok = halted && (int'(r) < NREGS);
      if (!ok || (we && r == 6'd0)) exp_ack = 1;
      else if (we) exp_ack = BEATS + 1;
      else exp_ack = BEATS + 2;
      e_rd = (ok && !we) ? model[r] : exp_rdata;
      dbg_req = 1'b1; dbg_we = we; dbg_reg = r; dbg_wdata = wd; dbg_halted = halted;
      for (int c = 0; c <= exp_ack + 1; c++) begin
         inj = (c == cf) && (c >= 1) && (c <= exp_ack);
         core_wen = inj && cf_wen;
         core_ren = inj && !cf_wen;
         core_waddr = 8'h00; core_wdata = 8'hFF; core_raddr = 8'($urandom);
         @(negedge clk);
         e_wen  = ok && we && (r != 6'd0) && (c >= 1) && (c <= BEATS);
         e_ren  = ok && !we && (c >= 1) && (c <= BEATS);
         e_addr = 8'(int'(r) * BEATS + c - 1);
         n_checks += 4;
         if (dbg_ack !== (c == exp_ack)) begin
            n_fail++; $display("FAIL ack r=%0d we=%0b c=%0d got=%b want=%b", r, we, c, dbg_ack, c == exp_ack);
         end
         if (ram_wen !== e_wen) begin
            n_fail++; $display("FAIL ram_wen r=%0d c=%0d got=%b want=%b", r, c, ram_wen, e_wen);
         end
         if (ram_ren !== e_ren) begin
            n_fail++; $display("FAIL ram_ren r=%0d c=%0d got=%b want=%b", r, c, ram_ren, e_ren);
         end
         if (conflict !== inj) begin
            n_fail++; $display("FAIL conflict r=%0d c=%0d got=%b want=%b", r, c, conflict, inj);
         end
         if (e_wen) begin
            n_checks++;
            if (ram_waddr !== e_addr || ram_wdata !== wd[8*(c-1) +: 8]) begin
               n_fail++; $display("FAIL wr_beat r=%0d c=%0d got=%h/%h want=%h/%h", r, c,
                                  ram_waddr, ram_wdata, e_addr, wd[8*(c-1) +: 8]);
            end
         end
         if (e_ren) begin
            n_checks++;
            if (ram_raddr !== e_addr) begin
               n_fail++; $display("FAIL rd_addr r=%0d c=%0d got=%h want=%h", r, c, ram_raddr, e_addr);
            end
         end
         if (c == exp_ack) begin
            n_checks += 2;
            if (dbg_err !== !ok) begin
               n_fail++; $display("FAIL err r=%0d halted=%0b got=%b want=%b", r, halted, dbg_err, !ok);
            end
            if (dbg_rdata !== e_rd) begin
               n_fail++; $display("FAIL rdata r=%0d got=%h want=%h", r, dbg_rdata, e_rd);
            end
            dbg_req = 1'b0;
         end
         @(posedge clk); #1;
      end
      dbg_req = 1'b0; core_wen = 1'b0; core_ren = 1'b0;
      if (ok && we && r != 6'd0) model[r] = wd;
      exp_rdata = e_rd;
      $display("txn we=%0b reg=%0d wdata=%h halted=%0b cf=%0d -> rdata=%h err=%0b",
               we, r, wd, halted, cf, dbg_rdata, !ok);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) init_img[i] = (i < 4) ? 8'h00 : 8'($urandom);
      for (int r = 0; r < 64; r++)
         model[r] = {init_img[4*r+3], init_img[4*r+2], init_img[4*r+1], init_img[4*r]};
      fill = 1'b1;
      @(posedge clk); #1;
      fill = 1'b0;
      for (int i = 0; i < 3; i++) begin
         core_waddr = 8'($urandom); core_wdata = 8'($urandom); core_raddr = 8'($urandom);
         core_wen = 1'b0; core_ren = 1'b0;
         @(negedge clk);
         n_checks += 3;
         if (dbg_ack !== 1'b0 || dbg_err !== 1'b0 || conflict !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got ack=%b err=%b conf=%b want 0", dbg_ack, dbg_err, conflict);
         end
         if (dbg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h want=0", dbg_rdata);
         end
         if (ram_waddr !== core_waddr || ram_wdata !== core_wdata || ram_raddr !== core_raddr) begin
            n_fail++; $display("FAIL reset_pass got=%h/%h/%h want=%h/%h/%h", ram_waddr, ram_wdata,
                               ram_raddr, core_waddr, core_wdata, core_raddr);
         end
         @(posedge clk); #1;
      end
      $display("txn reset state checked");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      core_wen = 1'b1; core_waddr = 8'h15; core_wdata = 8'hA5;
      @(negedge clk);
      n_checks++;
      if (ram_wen !== 1'b1 || ram_waddr !== 8'h15 || ram_wdata !== 8'hA5) begin
         n_fail++; $display("FAIL pass_wr got=%b/%h/%h want=1/15/a5", ram_wen, ram_waddr, ram_wdata);
      end
      @(posedge clk); #1;
      core_wen = 1'b0; core_ren = 1'b1; core_raddr = 8'h15;
      @(negedge clk);
      n_checks++;
      if (ram_ren !== 1'b1 || ram_raddr !== 8'h15) begin
         n_fail++; $display("FAIL pass_rd got=%b/%h want=1/15", ram_ren, ram_raddr);
      end
      @(posedge clk); #1;
      core_ren = 1'b0;
      @(negedge clk);
      n_checks++;
      if (core_rdata !== 8'hA5) begin
         n_fail++; $display("FAIL pass_rdata got=%h want=a5", core_rdata);
      end
      model[5][15:8] = 8'hA5;
      $display("txn core passthrough wr/rd addr=15 data=a5");
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      do_access(1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 0, 1'b0);
      do_access(1'b0, 6'd5, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_x0();
      do_access(1'b1, 6'd0, 32'h12345678, 1'b1, 0, 1'b0);
      do_access(1'b0, 6'd0, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_csr_and_halt();
      do_access(1'b1, 6'd33, 32'hCAFE0123, 1'b1, 0, 1'b0);
      do_access(1'b0, 6'd33, 32'h0, 1'b1, 0, 1'b0);
      do_access(1'b0, 6'd40, 32'h0, 1'b1, 0, 1'b0);
      do_access(1'b0, 6'd7, 32'h0, 1'b0, 0, 1'b0);
      do_access(1'b1, 6'd7, 32'h55AA55AA, 1'b0, 0, 1'b0);
   endtask

   task automatic test_conflict();
      do_access(1'b1, 6'd7, 32'h13579BDF, 1'b1, 2, 1'b1);
      do_access(1'b0, 6'd7, 32'h0, 1'b1, 3, 1'b0);
      do_access(1'b0, 6'd0, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] wd;
      wd = $urandom;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_reg = 6'd9; dbg_wdata = wd; dbg_halted = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (ram_wen !== (c >= 1)) begin
            n_fail++; $display("FAIL rstmid_wen c=%0d got=%b want=%b", c, ram_wen, c >= 1);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (ram_wen !== 1'b0 || dbg_ack !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_idle got wen=%b ack=%b want 0/0", ram_wen, dbg_ack);
      end
      if (dbg_rdata !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_rdata got=%h want=0", dbg_rdata);
      end
      dbg_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (dbg_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_noack c=%0d got=%b want=0", c, dbg_ack);
         end
         @(posedge clk); #1;
      end
      model[9][15:0] = wd[15:0];
      exp_rdata = 32'h0;
      $display("txn reset during write x9=%h, two beats kept", wd);
      do_access(1'b0, 6'd9, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_access(1'($urandom), 6'($urandom_range(0, 39)), $urandom,
                   ($urandom_range(0, 5) != 0), $urandom_range(0, 6), 1'($urandom));
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_passthrough();
      test_write_read();
      test_x0();
      test_csr_and_halt();
      test_conflict();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
